// File: rtl/fpro_bus_arbiter_if.sv
// FPro arbiter bus bundle: both requester ports, the shared FPro bus and status.
// The master modport is the arbiter's view; the slave modport is the view of
// the requesters and FPro slaves wired around it.
interface fpro_bus_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    // Requester M0 (MCS bridge side)
    logic              m0_req;
    logic              m0_wr;
    logic              m0_video;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rd_data;

    // Requester M1 (secondary master)
    logic              m1_req;
    logic              m1_wr;
    logic              m1_video;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rd_data;

    // Shared FPro bus
    logic              fp_mmio_cs;
    logic              fp_video_cs;
    logic              fp_wr;
    logic              fp_rd;
    logic [ADDR_W-1:0] fp_addr;
    logic [DATA_W-1:0] fp_wr_data;
    logic [DATA_W-1:0] fp_rd_data;

    // Status
    logic              busy;
    logic              grant;

    modport master (
        input  m0_req, m0_wr, m0_video, m0_addr, m0_wr_data,
        output m0_ack, m0_rd_data,
        input  m1_req, m1_wr, m1_video, m1_addr, m1_wr_data,
        output m1_ack, m1_rd_data,
        output fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
        input  fp_rd_data,
        output busy, grant
    );

    modport slave (
        output m0_req, m0_wr, m0_video, m0_addr, m0_wr_data,
        input  m0_ack, m0_rd_data,
        output m1_req, m1_wr, m1_video, m1_addr, m1_wr_data,
        input  m1_ack, m1_rd_data,
        input  fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
        output fp_rd_data,
        input  busy, grant
    );
endinterface

// File: rtl/fpro_bus_arbiter.sv
// Two-master FPro bus arbiter. Each granted request becomes one single-cycle
// FPro transaction (IDLE -> BUS -> ACK), read data is captured per master and
// the winner gets a one-cycle ack. Contention is round-robin by default.
// Build macro FPRO_ARB_FIXED_PRIO_EN: M0 always wins contention (M1 may starve).
module fpro_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    fpro_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state, state_n;

    // The registered fp_* outputs double as the transaction holding registers:
    // they are loaded from the winner when leaving IDLE and ignore the masters'
    // inputs until the next IDLE.
    logic              mmio_cs_q, mmio_cs_n;
    logic              video_cs_q, video_cs_n;
    logic              wr_q, wr_n;
    logic              rd_q, rd_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wr_data_q, wr_data_n;

    logic              grant_q, grant_n;
    logic              prio_q, prio_n;
    logic              m0_ack_q, m0_ack_n;
    logic              m1_ack_q, m1_ack_n;
    logic [DATA_W-1:0] m0_rd_data_q;
    logic [DATA_W-1:0] m1_rd_data_q;

    logic              pick;

    // Pick which master wins if a grant happens this cycle (0 = M0, 1 = M1).
    always_comb begin
        pick = 1'b0;
`ifdef FPRO_ARB_FIXED_PRIO_EN
        pick = ~bus.m0_req;
`else
        if (bus.m0_req && bus.m1_req) begin
            pick = prio_q;
        end else begin
            pick = bus.m1_req;
        end
`endif
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n    = state;
        mmio_cs_n  = 1'b0;
        video_cs_n = 1'b0;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        addr_n     = addr_q;
        wr_data_n  = wr_data_q;
        grant_n    = grant_q;
        prio_n     = prio_q;
        m0_ack_n   = 1'b0;
        m1_ack_n   = 1'b0;

        case (state)
            IDLE: begin
                addr_n    = '0;
                wr_data_n = '0;
                if (bus.m0_req || bus.m1_req) begin
                    state_n = BUS;
                    grant_n = pick;
                    if (pick) begin
                        wr_n       = bus.m1_wr;
                        rd_n       = ~bus.m1_wr;
                        video_cs_n = bus.m1_video;
                        mmio_cs_n  = ~bus.m1_video;
                        addr_n     = bus.m1_addr;
                        wr_data_n  = bus.m1_wr_data;
                    end else begin
                        wr_n       = bus.m0_wr;
                        rd_n       = ~bus.m0_wr;
                        video_cs_n = bus.m0_video;
                        mmio_cs_n  = ~bus.m0_video;
                        addr_n     = bus.m0_addr;
                        wr_data_n  = bus.m0_wr_data;
                    end
                end
            end
            BUS: begin
                state_n  = ACK;
                m0_ack_n = ~grant_q;
                m1_ack_n = grant_q;
            end
            ACK: begin
                state_n = IDLE;
                prio_n  = ~grant_q;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered bus outputs, acks, grant and priority pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmio_cs_q  <= 1'b0;
            video_cs_q <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            grant_q    <= 1'b0;
            prio_q     <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
        end else begin
            mmio_cs_q  <= mmio_cs_n;
            video_cs_q <= video_cs_n;
            wr_q       <= wr_n;
            rd_q       <= rd_n;
            addr_q     <= addr_n;
            wr_data_q  <= wr_data_n;
            grant_q    <= grant_n;
            prio_q     <= prio_n;
            m0_ack_q   <= m0_ack_n;
            m1_ack_q   <= m1_ack_n;
        end
    end

    // Capture slave read data at the end of a read strobe cycle for the winner only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rd_data_q <= '0;
            m1_rd_data_q <= '0;
        end else if (state == BUS && rd_q) begin
            if (grant_q) begin
                m1_rd_data_q <= bus.fp_rd_data;
            end else begin
                m0_rd_data_q <= bus.fp_rd_data;
            end
        end
    end

    assign bus.fp_mmio_cs  = mmio_cs_q;
    assign bus.fp_video_cs = video_cs_q;
    assign bus.fp_wr       = wr_q;
    assign bus.fp_rd       = rd_q;
    assign bus.fp_addr     = addr_q;
    assign bus.fp_wr_data  = wr_data_q;
    assign bus.m0_ack      = m0_ack_q;
    assign bus.m1_ack      = m1_ack_q;
    assign bus.m0_rd_data  = m0_rd_data_q;
    assign bus.m1_rd_data  = m1_rd_data_q;
    assign bus.busy        = (state != IDLE);
    assign bus.grant       = grant_q;

endmodule

// File: doc/fpro_bus_arbiter.md
Name: fpro_bus_arbiter

Overview:
- Shares the single FPro bus (mmio/video chip-selects, wr, rd, addr, wr_data, rd_data) between two masters: M0 (MCS bridge side) and M1 (secondary master, e.g. DMA or sampler engine).
- Serialises requests into single-cycle FPro transactions and captures read data.
- Returns a one-cycle acknowledge to the winning master.
- Sits between the bridge/secondary master and the mmio/video subsystems in the SoC top.

Parameters:
- ADDR_W, 21, FPro address width.
- DATA_W, 32, FPro data width.

Ports:
- clk  in  1  system clock (100 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  M0 request, level; held until m0_ack.
- m0_wr  in  1  M0 transaction type: 1 = write, 0 = read.
- m0_video  in  1  M0 target select: 1 = video space, 0 = mmio space.
- m0_addr  in  ADDR_W  M0 address.
- m0_wr_data  in  DATA_W  M0 write data.
- m0_ack  out  1  one-cycle completion pulse to M0.
- m0_rd_data  out  DATA_W  registered read data for M0; valid while m0_ack=1 and held afterwards.
- m1_req, m1_wr, m1_video, m1_addr, m1_wr_data, m1_ack, m1_rd_data  same as M0, for M1.
- fp_mmio_cs  out  1  FPro mmio chip-select.
- fp_video_cs  out  1  FPro video chip-select.
- fp_wr  out  1  FPro write strobe.
- fp_rd  out  1  FPro read strobe.
- fp_addr  out  ADDR_W  FPro address.
- fp_wr_data  out  DATA_W  FPro write data.
- fp_rd_data  in  DATA_W  FPro read data, combinational from the slave in the strobe cycle.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the master currently or last granted.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; all fp_* outputs 0; m0_ack and m1_ack 0; m*_rd_data 0; busy 0; grant 0; priority pointer favours M0.
- State machine: IDLE -> BUS -> ACK -> IDLE. Each transaction takes 3 cycles from request sample to ack. Peak throughput is one transaction per 3 cycles.
- IDLE:
  - If no req: stay in IDLE; fp_* outputs 0.
  - If exactly one req: grant that master.
  - If both req: grant the master indicated by the priority pointer.
  - On a grant: latch the winner's wr, video, addr and wr_data into holding registers; set grant; go to BUS.
- BUS (exactly 1 cycle):
  - fp_addr and fp_wr_data are driven from the holding registers.
  - fp_video_cs = video; fp_mmio_cs = ~video.
  - fp_wr = wr; fp_rd = ~wr.
  - On a read, fp_rd_data is sampled at the end of the cycle into the granted master's rd_data register. The other master's rd_data is unchanged. On a write, rd_data is unchanged.
  - Go to ACK.
- ACK:
  - All fp_* strobes and chip-selects are 0; fp_addr and fp_wr_data hold their values.
  - m<grant>_ack = 1 for exactly this cycle.
  - Priority pointer is set to the non-granted master (round-robin).
  - Go to IDLE.
- Requester rule: a master deasserts req, or presents a new transaction, on the clock edge where it sees ack. A req still high in the following IDLE cycle is treated as a new transaction.
- Request inputs are sampled only in IDLE. Changes to a master's inputs during BUS or ACK have no effect on the transaction in flight.
- Simultaneous requests: service strictly alternates, so under continuous contention each master waits at most one transaction (3 cycles).
- Reset asserted mid-transaction: the transaction is aborted immediately, no ack is issued, and all outputs return to reset values. A master must re-issue after reset.
- Chip-selects and strobes are registered outputs (glitch-free). fp_mmio_cs and fp_video_cs are never high together.

Optional Feature:
- Macro: FPRO_ARB_FIXED_PRIO_EN.
- Defined: M0 always wins simultaneous requests and the priority pointer is not used. Starvation of M1 under continuous M0 traffic is the intended behaviour.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Single write: M0 only, m0_wr=1, m0_video=0, addr=0x00040, data=0xDEADBEEF -> exactly 1 cycle with fp_mmio_cs=1, fp_wr=1, fp_addr=0x00040, fp_wr_data=0xDEADBEEF; m0_ack pulses 2 cycles after the req sample edge.
- Single read: M1 video read, addr=0x100000; slave returns 0x12345678 -> fp_video_cs=1, fp_rd=1 for 1 cycle; m1_rd_data=0x12345678 when m1_ack=1; m0_rd_data unchanged.
- Contention: both req asserted on the same cycle after reset, held for 4 transactions each -> grant order M0, M1, M0, M1, ...; each ack is 3 cycles apart. With FPRO_ARB_FIXED_PRIO_EN: all 4 M0 transactions complete before any M1 transaction.
- Input change during BUS: M0 changes m0_addr from 0x10 to 0x20 during the BUS cycle -> fp_addr stays 0x10 for the transaction.
- Reset mid-transaction: reset_n pulled low during BUS -> fp_* all 0 immediately, no ack pulse, busy=0; after release, a new req completes normally.
- Held req: M0 keeps req high for 1 cycle after ack -> a second transaction to the same address is issued (re-issue is detected and counted by the scoreboard).
